// File: rtl/id_stage.sv
// RV32 ALU-subset decode stage with a 31x32 register file and a one-entry valid/ready output register.
// Optional macro ID_WB_BYPASS_EN forwards same-cycle write-back data into the source operands.
module id_stage #(
    parameter int unsigned REGFILE_RESET = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_instr_valid,
    output logic        o_instr_ready,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic        i_wb_en,
    input  logic [4:0]  i_wb_rd,
    input  logic [31:0] i_wb_data,
    input  logic        i_flush,
    output logic        o_ex_valid,
    input  logic        i_ex_ready,
    output logic [2:0]  o_alu_op,
    output logic        o_alu_op2,
    output logic [31:0] o_alu_x,
    output logic [31:0] o_alu_y,
    output logic [4:0]  o_rd,
    output logic        o_rd_we,
    output logic        o_illegal
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    logic [XLEN-1:0] rf_q [1:31];

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [RW-1:0]   rs1, rs2, rd;
    logic [XLEN-1:0] rs1_rf, rs2_rf, rs1_val, rs2_val;
    logic            accept;

    logic            dec_legal;
    logic [2:0]      dec_op;
    logic            dec_op2;
    logic [XLEN-1:0] dec_x, dec_y;

    logic            ex_valid_d, ex_valid_q;
    logic [2:0]      alu_op_d, alu_op_q;
    logic            alu_op2_d, alu_op2_q;
    logic [XLEN-1:0] alu_x_d, alu_x_q, alu_y_d, alu_y_q;
    logic [RW-1:0]   rd_d, rd_q;
    logic            rd_we_d, rd_we_q;
    logic            illegal_d, illegal_q;

    assign opcode = i_instr[6:0];
    assign rd     = i_instr[11:7];
    assign funct3 = i_instr[14:12];
    assign rs1    = i_instr[19:15];
    assign rs2    = i_instr[24:20];
    assign funct7 = i_instr[31:25];

    assign o_instr_ready = !ex_valid_q || i_ex_ready;
    assign accept        = i_instr_valid && o_instr_ready && !i_flush;

    // Register file: writes are independent of stall/flush, blocked only by reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            if (REGFILE_RESET != 0) begin
                for (int i = 1; i < 32; i++) begin
                    rf_q[5'(i)] <= '0;
                end
            end
        end else if (i_wb_en && i_wb_rd != '0) begin
            rf_q[i_wb_rd] <= i_wb_data;
        end
    end

    assign rs1_rf = (rs1 == '0) ? '0 : rf_q[rs1];
    assign rs2_rf = (rs2 == '0) ? '0 : rf_q[rs2];

`ifdef ID_WB_BYPASS_EN
    assign rs1_val = (i_wb_en && rs1 != '0 && i_wb_rd == rs1) ? i_wb_data : rs1_rf;
    assign rs2_val = (i_wb_en && rs2 != '0 && i_wb_rd == rs2) ? i_wb_data : rs2_rf;
`else
    assign rs1_val = rs1_rf;
    assign rs2_val = rs2_rf;
`endif

    // Instruction decode; anything not explicitly legal leaves all fields zero.
    always_comb begin
        dec_legal = 1'b0;
        dec_op    = '0;
        dec_op2   = 1'b0;
        dec_x     = '0;
        dec_y     = '0;
        unique case (opcode)
            OPC_OP: begin
                if (funct7 == F7_ZERO ||
                    (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    dec_legal = 1'b1;
                    dec_op    = funct3;
                    dec_op2   = (funct7 == F7_ALT);
                    dec_x     = rs1_val;
                    dec_y     = rs2_val;
                end
            end
            OPC_OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    if (funct7 == F7_ZERO || (funct3 == 3'b101 && funct7 == F7_ALT)) begin
                        dec_legal = 1'b1;
                        dec_op    = funct3;
                        dec_op2   = (funct7 == F7_ALT);
                        dec_x     = rs1_val;
                        dec_y     = {27'b0, i_instr[24:20]};
                    end
                end else begin
                    dec_legal = 1'b1;
                    dec_op    = funct3;
                    dec_x     = rs1_val;
                    dec_y     = {{20{i_instr[31]}}, i_instr[31:20]};
                end
            end
            OPC_LUI: begin
                dec_legal = 1'b1;
                dec_y     = {i_instr[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                dec_legal = 1'b1;
                dec_x     = i_pc;
                dec_y     = {i_instr[31:12], 12'b0};
            end
            default: ;
        endcase
    end

    // Output register next state: flush beats accept, accept beats drain.
    always_comb begin
        ex_valid_d = ex_valid_q;
        alu_op_d   = alu_op_q;
        alu_op2_d  = alu_op2_q;
        alu_x_d    = alu_x_q;
        alu_y_d    = alu_y_q;
        rd_d       = rd_q;
        rd_we_d    = rd_we_q;
        illegal_d  = illegal_q;
        if (i_flush) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d = 1'b1;
            alu_op_d   = dec_op;
            alu_op2_d  = dec_op2;
            alu_x_d    = dec_x;
            alu_y_d    = dec_y;
            rd_d       = rd;
            rd_we_d    = dec_legal && rd != '0;
            illegal_d  = !dec_legal;
        end else if (i_ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ex_valid_q <= 1'b0;
            alu_op_q   <= '0;
            alu_op2_q  <= 1'b0;
            alu_x_q    <= '0;
            alu_y_q    <= '0;
            rd_q       <= '0;
            rd_we_q    <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            alu_op_q   <= alu_op_d;
            alu_op2_q  <= alu_op2_d;
            alu_x_q    <= alu_x_d;
            alu_y_q    <= alu_y_d;
            rd_q       <= rd_d;
            rd_we_q    <= rd_we_d;
            illegal_q  <= illegal_d;
        end
    end

    assign o_ex_valid = ex_valid_q;
    assign o_alu_op   = alu_op_q;
    assign o_alu_op2  = alu_op2_q;
    assign o_alu_x    = alu_x_q;
    assign o_alu_y    = alu_y_q;
    assign o_rd       = rd_q;
    assign o_rd_we    = rd_we_q;
    assign o_illegal  = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios then randomized traffic against a behavioural model.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [2:0]  alu_op;
    logic        alu_op2;
    logic [31:0] alu_x;
    logic [31:0] alu_y;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;

    int n_vec = 0;
    int n_err = 0;

    id_stage #(.REGFILE_RESET(1)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_instr_valid (instr_valid),
        .o_instr_ready (instr_ready),
        .i_instr       (instr),
        .i_pc          (pc),
        .i_wb_en       (wb_en),
        .i_wb_rd       (wb_rd),
        .i_wb_data     (wb_data),
        .i_flush       (flush),
        .o_ex_valid    (ex_valid),
        .i_ex_ready    (ex_ready),
        .o_alu_op      (alu_op),
        .o_alu_op2     (alu_op2),
        .o_alu_x       (alu_x),
        .o_alu_y       (alu_y),
        .o_rd          (rd),
        .o_rd_we       (rd_we),
        .o_illegal     (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [2:0]  op;
        logic        op2;
        logic [31:0] x;
        logic [31:0] y;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t        m;
    logic [31:0] mrf [32];

    // What the execute stage should see for one instruction, straight from the ISA rules.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] ipc,
                                        input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        int   f3, f7;
        bit   ok, sh;
        r  = '0;
        ok = 0;
        f3 = int'(ins[14:12]);
        f7 = int'(ins[31:25]);
        case (ins[6:0])
            7'h33: if (f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5))) begin
                ok = 1; r.op = 3'(f3); r.op2 = (f7 == 32); r.x = a; r.y = b;
            end
            7'h13: begin
                sh = (f3 == 1 || f3 == 5);
                if (!sh || f7 == 0 || (f3 == 5 && f7 == 32)) begin
                    ok = 1; r.op = 3'(f3); r.x = a;
                    r.op2 = sh && (f7 == 32);
                    r.y = sh ? 32'(ins[24:20]) : 32'($signed(ins[31:20]));
                end
            end
            7'h37: begin ok = 1; r.y = 32'(ins[31:12]) << 12; end
            7'h17: begin ok = 1; r.x = ipc; r.y = 32'(ins[31:12]) << 12; end
            default: ok = 0;
        endcase
        r.rd  = ins[11:7];
        r.we  = ok && (ins[11:7] != 0);
        r.ill = !ok;
        return r;
    endfunction

    function automatic logic [31:0] src(input logic [4:0] idx);
        if (idx == 0) return 32'h0;
`ifdef ID_WB_BYPASS_EN
        if (wb_en && wb_rd == idx) return wb_data;
`endif
        return mrf[idx];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Advance one clock with the inputs currently applied, updating the model alongside.
    task automatic step();
        logic acc, rdy;
        exp_t d;
        #1;
        rdy = !m.valid || ex_ready;
        if (rst_n) chk("ready", 32'(instr_ready), 32'(rdy));
        if (!rst_n) begin
            m = '0;
            for (int i = 0; i < 32; i++) mrf[i] = '0;
        end else begin
            acc = instr_valid && rdy && !flush;
            d   = ref_decode(instr, pc, src(instr[19:15]), src(instr[24:20]));
            if (flush) m.valid = 1'b0;
            else if (acc) begin m = d; m.valid = 1'b1; end
            else if (ex_ready) m.valid = 1'b0;
            if (wb_en && wb_rd != 0) mrf[wb_rd] = wb_data;
        end
        @(posedge clk);
        #1;
        chk("ex_valid", 32'(ex_valid), 32'(m.valid));
        chk("alu_op",   32'(alu_op),   32'(m.op));
        chk("alu_op2",  32'(alu_op2),  32'(m.op2));
        chk("alu_x",    alu_x,         m.x);
        chk("alu_y",    alu_y,         m.y);
        chk("rd",       32'(rd),       32'(m.rd));
        chk("rd_we",    32'(rd_we),    32'(m.we));
        chk("illegal",  32'(illegal),  32'(m.ill));
    endtask

    task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] p,
                       input logic er, input logic we, input logic [4:0] wr,
                       input logic [31:0] wd, input logic fl);
        instr_valid = v; instr = ins; pc = p; ex_ready = er;
        wb_en = we; wb_rd = wr; wb_data = wd; flush = fl;
        step();
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] r;
        int          s, k;
        r = $urandom;
        s = $urandom_range(0, 7);
        k = $urandom_range(0, 3);
        if (k < 2) r[31:25] = 7'h00;
        else if (k == 2) r[31:25] = 7'h20;
        case (s)
            0, 1: r[6:0] = 7'h33;
            2, 3: r[6:0] = 7'h13;
            4:    r[6:0] = 7'h37;
            5:    r[6:0] = 7'h17;
            6:    r[6:0] = 7'h03;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        logic [31:0] ri;
        m = '0;
        for (int i = 0; i < 32; i++) mrf[i] = '0;
        rst_n = 1'b0;
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 5'd9, 32'hdead, 0);
        rst_n = 1'b1;
        #1 chk("ready_after_reset", 32'(instr_ready), 32'd1);

        cyc(1, 32'h00500093, 32'h0, 1, 0, 0, 0, 0);
        chk("addi_y", alu_y, 32'd5);
        chk("addi_rd_we", 32'(rd_we), 32'd1);

        cyc(0, 0, 0, 1, 1, 5'd2, 32'd7, 0);
        cyc(0, 0, 0, 1, 1, 5'd3, 32'd3, 0);
        cyc(0, 0, 0, 1, 1, 5'd8, 32'h11, 0);
        cyc(1, 32'h40310233, 32'h0, 1, 0, 0, 0, 0);
        chk("sub_x", alu_x, 32'd7);
        chk("sub_op2", 32'(alu_op2), 32'd1);
        cyc(1, 32'h40415293, 32'h0, 1, 0, 0, 0, 0);
        chk("srai_y", alu_y, 32'd4);

        for (int i = 0; i < 3; i++) cyc(1, 32'hABCDE337, 32'h0, 0, 0, 0, 0, 0);
        chk("stall_ready", 32'(instr_ready), 32'd0);
        chk("stall_hold_op", 32'(alu_op), 32'd5);
        cyc(1, 32'hABCDE337, 32'h0, 1, 0, 0, 0, 0);
        chk("lui_y", alu_y, 32'hABCDE000);
        cyc(1, 32'h00001397, 32'h100, 1, 0, 0, 0, 0);
        chk("auipc_x", alu_x, 32'h100);
        chk("auipc_y", alu_y, 32'h1000);
        cyc(1, 32'h00002403, 32'h0, 1, 0, 0, 0, 0);
        chk("load_illegal", 32'(illegal), 32'd1);

        cyc(1, 32'h008403B3, 32'h0, 1, 1, 5'd8, 32'h55, 0);
`ifdef ID_WB_BYPASS_EN
        chk("add_bypass_x", alu_x, 32'h55);
`else
        chk("add_nobypass_x", alu_x, 32'h11);
`endif
        cyc(1, 32'h00100093, 32'h0, 0, 0, 0, 0, 1);
        chk("flush_valid", 32'(ex_valid), 32'd0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 32'h00100013, 32'h0, 1, 0, 0, 0, 0);
        chk("x0_rd_we", 32'(rd_we), 32'd0);

        for (int n = 0; n < 500; n++) begin
            ri = rnd_instr();
            rst_n = ($urandom_range(0, 63) != 0);
            cyc(($urandom_range(0, 3) != 0), ri, $urandom,
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0),
                ($urandom_range(0, 1) != 0) ? ri[19:15] : 5'($urandom),
                $urandom, ($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
